// File: rtl/sal_ref_ctrl_pkg.sv
// sal_ref_ctrl_pkg
//   Shared definitions for the per-bank auto-refresh scheduler:
//   FSM state encoding, owed-count width and parameter defaults.
package sal_ref_ctrl_pkg;

  typedef enum logic {
    S_OFF = 1'b0,
    S_RUN = 1'b1
  } state_t;

  localparam int OWED_W            = 5;
  localparam int MAX_POSTPONE_DEF  = 8;
  localparam int URGENT_THRESH_DEF = 6;

endpackage

// File: rtl/sal_ref_ctrl_if.sv
// sal_ref_ctrl_if
//   Refresh handshake between the scheduler and the bank controller.
//   bk_idle_i  - bank controller has no valid request pending
//   ref_gnt_i  - single-cycle REFRESH issued by the bank controller
//   ref_req_o  - refresh request towards the bank controller
//   urgent_o   - owed count at or above the urgency threshold
//   owed_o     - signed owed-refresh count
//   err_o      - sticky postpone-budget overflow flag
//   master: scheduler side, slave: bank controller / debug side.
interface sal_ref_ctrl_if;
  import sal_ref_ctrl_pkg::*;

  logic                     bk_idle_i;
  logic                     ref_gnt_i;
  logic                     ref_req_o;
  logic                     urgent_o;
  logic signed [OWED_W-1:0] owed_o;
  logic                     err_o;

  modport master (
    input  bk_idle_i, ref_gnt_i,
    output ref_req_o, urgent_o, owed_o, err_o
  );

  modport slave (
    output bk_idle_i, ref_gnt_i,
    input  ref_req_o, urgent_o, owed_o, err_o
  );

endinterface

// File: rtl/sal_ref_ctrl_interval_cntr.sv
// sal_ref_ctrl_interval_cntr
//   Reloadable down-counter timing the refresh interval.
//   clk, rst_n  - clock, async active-low reset
//   en          - count enable; counter is held at 0 while low
//   load        - load reload_val (takes priority over en)
//   reload_val  - value loaded on load and on every wrap, sampled then
//   tick        - one cycle while enabled with the counter at 0
module sal_ref_ctrl_interval_cntr #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] reload_val,
  output logic             tick
);

  logic [WIDTH-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= reload_val;
    else if (!en)        cnt <= '0;
    else if (cnt == '0)  cnt <= reload_val;
    else                 cnt <= cnt - WIDTH'(1);
  end

endmodule

// File: rtl/sal_ref_ctrl.sv
// sal_ref_ctrl
//   Per-bank auto-refresh scheduler. Times tREFI, tracks owed refreshes,
//   requests opportunistically while the bank is idle and forces refresh
//   once the owed count reaches URGENT_THRESH.
//   clk, rst_n  - clock, async active-low reset
//   t_refi_i    - tREFI in clocks (>= 2), sampled at each counter reload
//   ref_en_i    - refresh enable
//   bus         - refresh handshake (sal_ref_ctrl_if.master)
//   Optional macro SAL_REF_PULL_IN_EN: idle bank may pull refreshes in,
//   driving the owed count negative down to -MAX_POSTPONE.
//
//   state | meaning
//   ------+-------------------------------------------------
//   S_OFF | refresh disabled, interval counter held at 0
//   S_RUN | interval counter running, requests allowed
module sal_ref_ctrl
  import sal_ref_ctrl_pkg::*;
#(
  parameter int REFI_WIDTH    = 12,
  parameter int MAX_POSTPONE  = MAX_POSTPONE_DEF,
  parameter int URGENT_THRESH = URGENT_THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REFI_WIDTH-1:0] t_refi_i,
  input  logic                  ref_en_i,
  sal_ref_ctrl_if.master        bus
);

  typedef logic signed [OWED_W-1:0] owed_t;

  localparam owed_t OWED_MAX  = owed_t'(MAX_POSTPONE);
  localparam owed_t OWED_URG  = owed_t'(URGENT_THRESH);
  localparam owed_t OWED_ZERO = owed_t'(0);
  localparam owed_t OWED_ONE  = owed_t'(1);
`ifdef SAL_REF_PULL_IN_EN
  localparam owed_t OWED_FLOOR = owed_t'(-MAX_POSTPONE);
`else
  localparam owed_t OWED_FLOOR = OWED_ZERO;
`endif

  state_t state_q, state_nxt;
  owed_t  owed_q, owed_nxt;
  logic   err_q, err_nxt;
  logic   req_q, req_nxt;
  logic   urg_q, urg_nxt;
  logic   tick, load, run_nxt, gnt_eff;

  assign load    = (state_q == S_OFF) && (state_nxt == S_RUN);
  assign run_nxt = (state_nxt == S_RUN);

  sal_ref_ctrl_interval_cntr #(.WIDTH(REFI_WIDTH)) u_interval_cntr (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state_q == S_RUN),
    .load       (load),
    .reload_val (t_refi_i - REFI_WIDTH'(1)),
    .tick       (tick)
  );

  always_comb begin
    state_nxt = state_q;
    owed_nxt  = owed_q;
    err_nxt   = err_q;
    req_nxt   = 1'b0;
    urg_nxt   = 1'b0;
    gnt_eff   = 1'b0;

    case (state_q)
      S_OFF:   if (ref_en_i)  state_nxt = S_RUN;
      S_RUN:   if (!ref_en_i) state_nxt = S_OFF;
      default: state_nxt = S_OFF;
    endcase

    // A grant at the lower bound is spurious and simply dropped.
    gnt_eff = bus.ref_gnt_i && (owed_q > OWED_FLOOR);

    if (tick && !gnt_eff) begin
      if (owed_q == OWED_MAX) err_nxt  = 1'b1;
      else                    owed_nxt = owed_q + OWED_ONE;
    end else if (!tick && gnt_eff) begin
      owed_nxt = owed_q - OWED_ONE;
    end

    // Outputs are registered from next-state values so a grant that
    // retires the last owed refresh drops the request on the same edge.
    req_nxt = run_nxt && (owed_nxt > OWED_ZERO) &&
              (bus.bk_idle_i || (owed_nxt >= OWED_URG));
`ifdef SAL_REF_PULL_IN_EN
    req_nxt = req_nxt || (run_nxt && bus.bk_idle_i &&
                          (owed_nxt <= OWED_ZERO) && (owed_nxt > OWED_FLOOR));
`endif
    urg_nxt = (owed_nxt >= OWED_URG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      owed_q  <= OWED_ZERO;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      urg_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      owed_q  <= owed_nxt;
      err_q   <= err_nxt;
      req_q   <= req_nxt;
      urg_q   <= urg_nxt;
    end
  end

  assign bus.ref_req_o = req_q;
  assign bus.urgent_o  = urg_q;
  assign bus.owed_o    = owed_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_sal_ref_ctrl.sv
module tb_sal_ref_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] t_refi;
  logic        ref_en;

  sal_ref_ctrl_if bus();

  sal_ref_ctrl #(
    .REFI_WIDTH    (12),
    .MAX_POSTPONE  (8),
    .URGENT_THRESH (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .t_refi_i (t_refi),
    .ref_en_i (ref_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit en;
    bit idle;
    bit gnt;
    int req;
    int urg;
    int owed;
    int err;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int req, input int urg,
                         input int owed, input int err);
    chk({tag, ".req"},  int'(bus.ref_req_o), req);
    chk({tag, ".urg"},  int'(bus.urgent_o),  urg);
    chk({tag, ".owed"}, int'($signed(bus.owed_o)), owed);
    chk({tag, ".err"},  int'(bus.err_o),     err);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    ref_en        = 1'b0;
    bus.bk_idle_i = 1'b0;
    bus.ref_gnt_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    t_refi = 12'd100;
    do_reset();
    chk_out("reset", 0, 0, 0, 0);

`ifdef SAL_REF_PULL_IN_EN
    // Pull-in: idle bank takes 8 refreshes early, ticks then repay them.
    t_refi = 12'd100;
    ref_en = 1'b1;
    bus.bk_idle_i = 1'b1;
    step(1);
    chk("pull.edge1.req", int'(bus.ref_req_o), 1);
    bus.ref_gnt_i = 1'b1;
    step(8);
    chk("pull.floor.owed", int'($signed(bus.owed_o)), -8);
    chk("pull.floor.req",  int'(bus.ref_req_o), 0);
    step(1);
    bus.ref_gnt_i = 1'b0;
    chk("pull.spurious.owed", int'($signed(bus.owed_o)), -8);
    chk("pull.spurious.err",  int'(bus.err_o), 0);
    bus.bk_idle_i = 1'b0;
    step(90);
    chk("pull.e100.owed", int'($signed(bus.owed_o)), -8);
    step(1);
    chk("pull.e101.owed", int'($signed(bus.owed_o)), -7);
    step(600);
    chk("pull.e701.owed", int'($signed(bus.owed_o)), -1);
    step(100);
    chk_out("pull.e801", 0, 0, 0, 0);
    step(100);
    chk_out("pull.e901", 0, 0, 1, 0);
`else
    // Basic request/grant, tREFI = 100.
    t_refi = 12'd100;
    ref_en = 1'b1;
    bus.bk_idle_i = 1'b1;
    step(100);
    chk_out("basic.e100", 0, 0, 0, 0);
    step(1);
    chk_out("basic.e101", 1, 0, 1, 0);
    step(2);
    chk("basic.e103.req", int'(bus.ref_req_o), 1);
    bus.ref_gnt_i = 1'b1;
    step(1);
    bus.ref_gnt_i = 1'b0;
    chk_out("basic.e104", 0, 0, 0, 0);

    // Per-cycle table, tREFI = 3: ticks on clocks 3, 6, 9.
    do_reset();
    t_refi = 12'd3;
    //          en idle gnt  req urg owed err
    tbl[0]  = '{1, 1, 0,   0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0,   0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0,   0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0,   1, 0, 1, 0};
    tbl[4]  = '{1, 0, 0,   0, 0, 1, 0};
    tbl[5]  = '{1, 1, 0,   1, 0, 1, 0};
    tbl[6]  = '{1, 1, 1,   1, 0, 1, 0};
    tbl[7]  = '{1, 1, 1,   0, 0, 0, 0};
    tbl[8]  = '{1, 1, 1,   0, 0, 0, 0};
    tbl[9]  = '{1, 1, 0,   1, 0, 1, 0};
    tbl[10] = '{0, 1, 0,   0, 0, 1, 0};
    tbl[11] = '{0, 1, 0,   0, 0, 1, 0};
    tbl[12] = '{1, 1, 0,   1, 0, 1, 0};
    tbl[13] = '{1, 1, 1,   0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      ref_en        = tbl[i].en;
      bus.bk_idle_i = tbl[i].idle;
      bus.ref_gnt_i = tbl[i].gnt;
      step(1);
      chk_out($sformatf("tbl%0d", i), tbl[i].req, tbl[i].urg,
              tbl[i].owed, tbl[i].err);
    end
    bus.ref_gnt_i = 1'b0;

    // Postpone and urgency, tREFI = 10, busy bank.
    do_reset();
    t_refi = 12'd10;
    ref_en = 1'b1;
    bus.bk_idle_i = 1'b0;
    step(60);
    chk_out("post.e60", 0, 0, 5, 0);
    step(1);
    chk_out("post.e61", 1, 1, 6, 0);
    step(20);
    chk_out("post.e81", 1, 1, 8, 0);
    step(9);
    chk("post.e90.err", int'(bus.err_o), 0);
    step(1);
    chk_out("post.e91", 1, 1, 8, 1);

    // Drain to 3, then a grant on the tick cycle (clock 100).
    bus.ref_gnt_i = 1'b1;
    step(5);
    bus.ref_gnt_i = 1'b0;
    chk_out("simul.e96", 0, 0, 3, 1);
    step(4);
    chk("simul.e100.owed", int'($signed(bus.owed_o)), 3);
    bus.ref_gnt_i = 1'b1;
    step(1);
    chk_out("simul.e101", 0, 0, 3, 1);

    // Owed 2, idle bank, then disable and re-enable.
    bus.bk_idle_i = 1'b1;
    step(1);
    bus.ref_gnt_i = 1'b0;
    chk_out("dis.e102", 1, 0, 2, 1);
    ref_en = 1'b0;
    step(1);
    chk_out("dis.e103", 0, 0, 2, 1);
    step(2);
    ref_en = 1'b1;
    step(1);
    chk_out("dis.e106", 1, 0, 2, 1);
    step(9);
    chk("dis.e115.owed", int'($signed(bus.owed_o)), 2);
    step(1);
    chk_out("dis.e116", 1, 0, 3, 1);

    // Async reset between edges while requesting.
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("areset", 0, 0, 0, 0);
    do_reset();
    chk_out("areset.post", 0, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
